// File: rtl/jt9346_dump_ctrl.sv
// Dump-port sequencer: serialises host image load and full-image save onto the EEPROM dump port.
// Optional feature macro JT9346_AUTOSAVE_EN: a raised dump_flag in IDLE starts a save like sv_req.
module jt9346_dump_ctrl #(
  parameter int AW    = 6,
  parameter int DW    = 8,
  parameter int BW    = (DW == 16) ? AW + 1 : AW,
  parameter int RDLAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  input  logic          sv_req,
  output logic          sv_valid,
  output logic [7:0]    sv_data,
  output logic          sv_last,
  input  logic          sv_ready,
  output logic          busy,
  output logic [BW-1:0] dump_addr,
  output logic          dump_we,
  output logic [7:0]    dump_din,
  input  logic [7:0]    dump_dout,
  input  logic          dump_flag,
  output logic          dump_clr
);

  // Handshakes: a byte moves on a clock edge where valid and ready are both high;
  // a source holds its data stable while valid is high and ready is low.

  typedef enum logic [2:0] {IDLE, LOAD, RD_ADDR, RD_WAIT, RD_OUT} state_t;

  localparam logic [BW-1:0] LAST      = {BW{1'b1}};
  localparam logic [1:0]    WAIT_LAST = 2'(RDLAT - 1);

  state_t        state, state_nx;
  logic [BW-1:0] cnt, cnt_nx;
  logic [1:0]    wcnt, wcnt_nx;
  logic [7:0]    sv_q, sv_q_nx;
  logic          save_trig;

`ifdef JT9346_AUTOSAVE_EN
  assign save_trig = sv_req | dump_flag;
`else
  logic unused_flag;
  assign unused_flag = dump_flag;
  assign save_trig   = sv_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      sv_q  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      wcnt  <= wcnt_nx;
      sv_q  <= sv_q_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wcnt_nx   = wcnt;
    sv_q_nx   = sv_q;
    ld_ready  = 1'b0;
    sv_valid  = 1'b0;
    sv_last   = 1'b0;
    dump_addr = '0;
    dump_we   = 1'b0;
    dump_din  = '0;
    dump_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (ld_start) begin
          state_nx = LOAD;
          cnt_nx   = '0;
        end else if (save_trig) begin
          state_nx = RD_ADDR;
          cnt_nx   = '0;
        end
      end
      LOAD: begin
        dump_addr = cnt;
        // A restart takes the cycle, so no byte is accepted alongside it.
        if (ld_start) begin
          cnt_nx = '0;
        end else begin
          ld_ready = 1'b1;
          if (ld_valid) begin
            dump_we  = 1'b1;
            dump_din = ld_data;
            cnt_nx   = cnt + BW'(1);
            if (cnt == LAST) begin
              dump_clr = 1'b1;
              state_nx = IDLE;
            end
          end
        end
      end
      RD_ADDR: begin
        dump_addr = cnt;
        dump_clr  = (cnt == '0);
        wcnt_nx   = '0;
        state_nx  = RD_WAIT;
      end
      RD_WAIT: begin
        // Address stays on the port until the read byte is captured.
        dump_addr = cnt;
        if (wcnt == WAIT_LAST) begin
          sv_q_nx  = dump_dout;
          state_nx = RD_OUT;
        end else begin
          wcnt_nx = wcnt + 2'd1;
        end
      end
      RD_OUT: begin
        sv_valid = 1'b1;
        sv_last  = (cnt == LAST);
        if (sv_ready) begin
          cnt_nx   = cnt + BW'(1);
          state_nx = (cnt == LAST) ? IDLE : RD_ADDR;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign sv_data = sv_q;

endmodule
